// File: rtl/kamacore_pkg.sv
// rtl/kamacore_pkg.sv - shared constants, state type and decode helper for the kamacore memory stage
package kamacore_pkg;

  localparam int CPU_WIDTH = 32;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // Non-memory opcodes that produce a register result.
  function automatic logic opcode_writes_rd(input logic [6:0] opcode);
    logic writes;
    case (opcode)
      OPCODE_OP, OPCODE_OP_IMM, OPCODE_LUI,
      OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR: writes = 1'b1;
      default:                               writes = 1'b0;
    endcase
    return writes;
  endfunction

endpackage

// File: rtl/kamacore_lsu_align.sv
// rtl/kamacore_lsu_align.sv - byte-lane placement, alignment check and load extension
module kamacore_lsu_align
  import kamacore_pkg::*;
(
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           offset_i,
  input  logic [CPU_WIDTH-1:0] rs2_i,
  input  logic [31:0]          rdata_i,
  output logic [3:0]           be_o,
  output logic [31:0]          wdata_o,
  output logic                 misalign_o,
  output logic [CPU_WIDTH-1:0] load_data_o
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Store data is replicated across lanes so only the byte enables select the target bytes.
  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = rs2_i;
    misalign_o = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{rs2_i[7:0]}};
      end
      2'b01: begin
        be_o       = 4'b0011 << offset_i;
        wdata_o    = {2{rs2_i[15:0]}};
        misalign_o = offset_i[0];
      end
      default: misalign_o = (offset_i != 2'b00);
    endcase
  end

  // Pick the addressed lane out of the full read word and extend it to register width.
  always_comb begin
    lane_byte = rdata_i[{offset_i, 3'b000} +: 8];
    lane_half = rdata_i[{offset_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    load_data_o = {{(CPU_WIDTH-8){lane_byte[7]}}, lane_byte};
      F3_H:    load_data_o = {{(CPU_WIDTH-16){lane_half[15]}}, lane_half};
      F3_BU:   load_data_o = {{(CPU_WIDTH-8){1'b0}}, lane_byte};
      F3_HU:   load_data_o = {{(CPU_WIDTH-16){1'b0}}, lane_half};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/kamacore_stage_mem.sv
// rtl/kamacore_stage_mem.sv - memory-access pipeline stage with valid/ready data port and MEM/WB register
module kamacore_stage_mem
  import kamacore_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [CPU_WIDTH-1:0] ex_alu_result,
  input  logic [31:0]          ex_instruction,
  input  logic [CPU_WIDTH-1:0] ex_rs2_data,
  output logic                 stall,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic [31:0]          dmem_addr,
  output logic                 dmem_we,
  output logic [3:0]           dmem_be,
  output logic [31:0]          dmem_wdata,
  input  logic                 dmem_rsp_valid,
  input  logic [31:0]          dmem_rdata,
  output logic                 wb_valid,
  output logic [31:0]          wb_instruction,
  output logic [CPU_WIDTH-1:0] wb_result,
  output logic                 wb_rd_we,
  output logic                 misalign_exc
);

  mem_state_e state_q, state_d;

  logic [CPU_WIDTH-1:0] addr_q, addr_d;
  logic [CPU_WIDTH-1:0] rs2_q, rs2_d;
  logic [2:0]           funct3_q, funct3_d;
  logic                 store_q, store_d;
  logic [31:0]          instr_q, instr_d;

  logic                 wb_valid_q, wb_valid_d;
  logic                 wb_rd_we_q, wb_rd_we_d;
  logic [31:0]          wb_instr_q, wb_instr_d;
  logic [CPU_WIDTH-1:0] wb_result_q, wb_result_d;

  logic [6:0] ex_opcode;
  logic [2:0] ex_funct3;
  logic [4:0] ex_rd;
  logic       ex_is_load;
  logic       ex_is_store;
  logic       ex_is_mem;

  assign ex_opcode   = ex_instruction[6:0];
  assign ex_funct3   = ex_instruction[14:12];
  assign ex_rd       = ex_instruction[11:7];
  assign ex_is_load  = (ex_opcode == OPCODE_LOAD);
  assign ex_is_store = (ex_opcode == OPCODE_STORE);
  assign ex_is_mem   = ex_is_load | ex_is_store;

  // In IDLE the aligner checks the incoming EX entry; afterwards it works from the latched access.
  logic                 in_idle;
  logic [2:0]           al_funct3;
  logic [1:0]           al_offset;
  logic [3:0]           al_be;
  logic [31:0]          al_wdata;
  logic                 al_misalign;
  logic [CPU_WIDTH-1:0] al_load_data;

  assign in_idle   = (state_q == IDLE);
  assign al_funct3 = in_idle ? ex_funct3 : funct3_q;
  assign al_offset = in_idle ? ex_alu_result[1:0] : addr_q[1:0];

  kamacore_lsu_align u_align (
    .funct3_i    (al_funct3),
    .offset_i    (al_offset),
    .rs2_i       (rs2_q),
    .rdata_i     (dmem_rdata),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .misalign_o  (al_misalign),
    .load_data_o (al_load_data)
  );

  // Next-state, access latching, MEM/WB update and stall/request/exception outputs.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    rs2_d          = rs2_q;
    funct3_d       = funct3_q;
    store_d        = store_q;
    instr_d        = instr_q;
    wb_valid_d     = 1'b0;
    wb_rd_we_d     = 1'b0;
    wb_instr_d     = wb_instr_q;
    wb_result_d    = wb_result_q;
    stall          = 1'b0;
    dmem_req_valid = 1'b0;
    misalign_exc   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!ex_is_mem) begin
            wb_valid_d  = 1'b1;
            wb_result_d = ex_alu_result;
            wb_instr_d  = ex_instruction;
            wb_rd_we_d  = opcode_writes_rd(ex_opcode) && (ex_rd != 5'd0);
          end else if (al_misalign) begin
            misalign_exc = 1'b1;
            wb_valid_d   = 1'b1;
            wb_result_d  = ex_alu_result;
            wb_instr_d   = ex_instruction;
          end else begin
            addr_d   = ex_alu_result;
            rs2_d    = ex_rs2_data;
            funct3_d = ex_funct3;
            store_d  = ex_is_store;
            instr_d  = ex_instruction;
            state_d  = REQ;
            stall    = 1'b1;
          end
        end
      end
      REQ: begin
        dmem_req_valid = 1'b1;
        if (dmem_req_ready && store_q) begin
          state_d     = IDLE;
          wb_valid_d  = 1'b1;
          wb_result_d = addr_q;
          wb_instr_d  = instr_q;
        end else begin
          stall = 1'b1;
          if (dmem_req_ready) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (dmem_rsp_valid) begin
          state_d     = IDLE;
          wb_valid_d  = 1'b1;
          wb_result_d = al_load_data;
          wb_instr_d  = instr_q;
          wb_rd_we_d  = (instr_q[11:7] != 5'd0);
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched access and MEM/WB register; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rs2_q       <= '0;
      funct3_q    <= '0;
      store_q     <= 1'b0;
      instr_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_we_q  <= 1'b0;
      wb_instr_q  <= '0;
      wb_result_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rs2_q       <= rs2_d;
      funct3_q    <= funct3_d;
      store_q     <= store_d;
      instr_q     <= instr_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_we_q  <= wb_rd_we_d;
      wb_instr_q  <= wb_instr_d;
      wb_result_q <= wb_result_d;
    end
  end

  assign dmem_addr      = {addr_q[31:2], 2'b00};
  assign dmem_we        = store_q;
  assign dmem_be        = al_be;
  assign dmem_wdata     = al_wdata;
  assign wb_valid       = wb_valid_q;
  assign wb_instruction = wb_instr_q;
  assign wb_result      = wb_result_q;
  assign wb_rd_we       = wb_rd_we_q;

endmodule

// File: tb/tb_kamacore_stage_mem.sv
// tb/tb_kamacore_stage_mem.sv - self-checking bench for the kamacore memory stage
module tb_kamacore_stage_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_instruction;
  logic [31:0] ex_rs2_data;
  logic        stall;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_instruction;
  logic [31:0] wb_result;
  logic        wb_rd_we;
  logic        misalign_exc;

  kamacore_stage_mem dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_instruction(ex_instruction), .ex_rs2_data(ex_rs2_data), .stall(stall),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_instruction(wb_instruction), .wb_result(wb_result), .wb_rd_we(wb_rd_we),
    .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] bus_mem [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];

  logic [6:0] alu_ops [8] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                              7'b1101111, 7'b1100111, 7'b1100011, 7'b0001111};
  bit         alu_wr  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [2:0] ld_f3   [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  int          obs_lat, obs_stall, obs_mis, obs_unstable, obs_req_cycle;
  bit          obs_got_req;
  logic [31:0] obs_addr, obs_wdata, obs_wb_instr, obs_wb_result;
  logic        obs_we, obs_wb_rd_we;
  logic [3:0]  obs_be;

  function automatic logic [31:0] mk_instr(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000000, 5'd2, 5'd1, f3, rd, op};
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h1234_5678;
  endfunction

  function automatic logic [31:0] bus_read(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Reference: a byte lane is enabled when it lies inside [off, off+size).
  function automatic logic [3:0] ref_be(input int size, input int off);
    logic [3:0] b = 4'b0000;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + size) b[i] = 1'b1;
    return b;
  endfunction

  // Reference: lane i carries store byte (i mod size).
  function automatic logic [31:0] ref_wdata(input logic [31:0] rs2, input int size);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % size) +: 8];
    return w;
  endfunction

  function automatic void ref_store(input logic [31:0] addr, input logic [31:0] rs2, input int size);
    logic [31:0] al = addr & 32'hFFFF_FFFC;
    logic [31:0] w  = ref_read(al);
    int off = int'(addr[1:0]);
    for (int i = off; i < off + size; i++) w[8*i +: 8] = rs2[8*(i-off) +: 8];
    ref_mem[al] = w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3, input int off);
    logic [31:0] v = word >> (8*off);
    int t;
    case (f3)
      3'b000: begin t = int'(v[7:0]);  if (t >= 128)   t = t - 256;   return t; end
      3'b001: begin t = int'(v[15:0]); if (t >= 32768) t = t - 65536; return t; end
      3'b100: return v & 32'h0000_00FF;
      3'b101: return v & 32'h0000_FFFF;
      default: return word;
    endcase
  endfunction

  // Presents one EX entry (called at posedge+1), acts as the data memory and records what the DUT did.
  task automatic do_op(input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] rs2,
                       input int rdy_dly, input int rsp_dly);
    int wait_q = 0;
    int wait_r = 0;
    int c = 0;
    bit pending = 0;
    bit done = 0;
    bit accept, stall_now;
    obs_lat = -1; obs_stall = 0; obs_mis = 0; obs_unstable = 0; obs_req_cycle = -1; obs_got_req = 0;
    ex_valid = 1'b1; ex_instruction = instr; ex_alu_result = addr; ex_rs2_data = rs2;
    while (!done && c < 40) begin
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      if (dmem_req_valid) begin
        dmem_req_ready = (wait_q >= rdy_dly);
        if (!dmem_req_ready) wait_q++;
      end
      if (pending) begin
        if (wait_r >= rsp_dly) begin
          dmem_rsp_valid = 1'b1;
          dmem_rdata = bus_read(obs_addr);
        end else wait_r++;
      end
      @(negedge clk);
      if (stall) obs_stall++;
      if (misalign_exc) obs_mis++;
      if (dmem_req_valid) begin
        if (!obs_got_req) begin
          obs_got_req = 1; obs_req_cycle = c;
          obs_addr = dmem_addr; obs_we = dmem_we; obs_be = dmem_be; obs_wdata = dmem_wdata;
        end else if (dmem_addr !== obs_addr || dmem_we !== obs_we || dmem_be !== obs_be || dmem_wdata !== obs_wdata) begin
          obs_unstable++;
        end
      end
      accept = dmem_req_valid && dmem_req_ready;
      stall_now = stall;
      @(posedge clk);
      #1;
      if (accept) begin
        if (obs_we) begin
          logic [31:0] w = bus_read(obs_addr);
          for (int i = 0; i < 4; i++) if (obs_be[i]) w[8*i +: 8] = obs_wdata[8*i +: 8];
          bus_mem[obs_addr] = w;
        end else pending = 1;
      end
      if (dmem_rsp_valid) pending = 0;
      if (!stall_now) ex_valid = 1'b0;
      c++;
      if (wb_valid) begin
        done = 1; obs_lat = c;
        obs_wb_instr = wb_instruction; obs_wb_result = wb_result; obs_wb_rd_we = wb_rd_we;
      end
    end
    ex_valid = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wb_valid: got %b expected 0", wb_valid); end
    vectors++; if (wb_instruction !== 32'h0) begin miscompares++; $display("FAIL rst_wb_instr: got %h expected 0", wb_instruction); end
    vectors++; if (wb_result !== 32'h0) begin miscompares++; $display("FAIL rst_wb_result: got %h expected 0", wb_result); end
    vectors++; if (wb_rd_we !== 1'b0) begin miscompares++; $display("FAIL rst_wb_rd_we: got %b expected 0", wb_rd_we); end
    vectors++; if (dmem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b expected 0", dmem_req_valid); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b expected 0", stall); end
    vectors++; if (misalign_exc !== 1'b0) begin miscompares++; $display("FAIL rst_misalign: got %b expected 0", misalign_exc); end
  endtask

  task automatic test_alu();
    do_op(mk_instr(7'b0110011, 3'b000, 5'd5), 32'h0000_1234, 32'h0, 0, 0);
    vectors++; if (obs_lat !== 1) begin miscompares++; $display("FAIL add_latency: got %0d expected 1", obs_lat); end
    vectors++; if (obs_wb_result !== 32'h0000_1234) begin miscompares++; $display("FAIL add_result: got %h expected 00001234", obs_wb_result); end
    vectors++; if (obs_wb_rd_we !== 1'b1) begin miscompares++; $display("FAIL add_rd_we: got %b expected 1", obs_wb_rd_we); end
    vectors++; if (obs_stall !== 0) begin miscompares++; $display("FAIL add_stall: got %0d cycles expected 0", obs_stall); end
    @(posedge clk); #1;
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL bubble_wb_valid: got %b expected 0", wb_valid); end
    for (int n = 0; n < 16; n++) begin
      int k = int'($urandom_range(0, 7));
      logic [4:0] rd = 5'($urandom_range(0, 31));
      logic [31:0] res = $urandom;
      logic [31:0] instr = mk_instr(alu_ops[k], 3'($urandom_range(0, 7)), rd);
      do_op(instr, res, $urandom, 0, 0);
      vectors++; if (obs_lat !== 1) begin miscompares++; $display("FAIL alu_latency op=%b: got %0d expected 1", alu_ops[k], obs_lat); end
      vectors++; if (obs_wb_result !== res) begin miscompares++; $display("FAIL alu_result: got %h expected %h", obs_wb_result, res); end
      vectors++; if (obs_wb_instr !== instr) begin miscompares++; $display("FAIL alu_instr: got %h expected %h", obs_wb_instr, instr); end
      vectors++; if (obs_wb_rd_we !== (alu_wr[k] && rd != 5'd0)) begin miscompares++; $display("FAIL alu_rd_we op=%b rd=%0d: got %b expected %b", alu_ops[k], rd, obs_wb_rd_we, (alu_wr[k] && rd != 5'd0)); end
      vectors++; if (obs_stall !== 0 || obs_got_req) begin miscompares++; $display("FAIL alu_no_stall: got stall=%0d req=%b expected 0/0", obs_stall, obs_got_req); end
    end
  endtask

  task automatic test_load();
    bus_mem[32'h100] = 32'h80FF_0000;
    ref_mem[32'h100] = 32'h80FF_0000;
    do_op(mk_instr(OP_LOAD, 3'b000, 5'd7), 32'h103, 32'h0, 0, 0);
    vectors++; if (obs_addr !== 32'h100) begin miscompares++; $display("FAIL lb_addr: got %h expected 00000100", obs_addr); end
    vectors++; if (obs_lat !== 3) begin miscompares++; $display("FAIL lb_latency: got %0d expected 3", obs_lat); end
    vectors++; if (obs_wb_result !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_result: got %h expected ffffff80", obs_wb_result); end
    vectors++; if (obs_wb_rd_we !== 1'b1) begin miscompares++; $display("FAIL lb_rd_we: got %b expected 1", obs_wb_rd_we); end
    do_op(mk_instr(OP_LOAD, 3'b100, 5'd7), 32'h103, 32'h0, 0, 0);
    vectors++; if (obs_wb_result !== 32'h0000_0080) begin miscompares++; $display("FAIL lbu_result: got %h expected 00000080", obs_wb_result); end
    vectors++; if (obs_req_cycle !== 1) begin miscompares++; $display("FAIL lbu_req_cycle: got %0d expected 1", obs_req_cycle); end
  endtask

  task automatic test_store_delayed();
    do_op(mk_instr(OP_STORE, 3'b001, 5'd0), 32'h202, 32'hDEAD_BEEF, 2, 0);
    ref_store(32'h202, 32'hDEAD_BEEF, 2);
    vectors++; if (obs_be !== 4'b1100) begin miscompares++; $display("FAIL sh_be: got %b expected 1100", obs_be); end
    vectors++; if (obs_wdata !== 32'hBEEF_BEEF) begin miscompares++; $display("FAIL sh_wdata: got %h expected beefbeef", obs_wdata); end
    vectors++; if (obs_stall !== 3) begin miscompares++; $display("FAIL sh_stall: got %0d cycles expected 3", obs_stall); end
    vectors++; if (obs_wb_rd_we !== 1'b0) begin miscompares++; $display("FAIL sh_rd_we: got %b expected 0", obs_wb_rd_we); end
    vectors++; if (obs_lat !== 4) begin miscompares++; $display("FAIL sh_latency: got %0d expected 4", obs_lat); end
    vectors++; if (obs_unstable !== 0) begin miscompares++; $display("FAIL sh_stable: got %0d changes expected 0", obs_unstable); end
    vectors++; if (obs_we !== 1'b1) begin miscompares++; $display("FAIL sh_we: got %b expected 1", obs_we); end
  endtask

  task automatic test_misalign();
    do_op(mk_instr(OP_LOAD, 3'b010, 5'd4), 32'h301, 32'h0, 0, 0);
    vectors++; if (obs_mis !== 1) begin miscompares++; $display("FAIL lw_mis_pulse: got %0d cycles expected 1", obs_mis); end
    vectors++; if (obs_got_req !== 1'b0) begin miscompares++; $display("FAIL lw_mis_no_req: got %b expected 0", obs_got_req); end
    vectors++; if (obs_lat !== 1) begin miscompares++; $display("FAIL lw_mis_wb: got latency %0d expected 1", obs_lat); end
    vectors++; if (obs_wb_rd_we !== 1'b0) begin miscompares++; $display("FAIL lw_mis_rd_we: got %b expected 0", obs_wb_rd_we); end
    vectors++; if (obs_stall !== 0) begin miscompares++; $display("FAIL lw_mis_stall: got %0d expected 0", obs_stall); end
  endtask

  task automatic test_random_mem();
    for (int n = 0; n < 40; n++) begin
      bit          is_st = 1'($urandom_range(0, 1));
      logic [2:0]  f3 = is_st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      logic [4:0]  rd = 5'($urandom_range(0, 31));
      logic [31:0] addr = 32'h600 + $urandom_range(0, 31);
      logic [31:0] rs2 = $urandom;
      logic [31:0] instr = mk_instr(is_st ? OP_STORE : OP_LOAD, f3, rd);
      int rq = int'($urandom_range(0, 3));
      int rp = int'($urandom_range(0, 3));
      int size = 1 << f3[1:0];
      int off = int'(addr[1:0]);
      logic [31:0] exp;
      do_op(instr, addr, rs2, rq, rp);
      if ((off % size) != 0) begin
        vectors++; if (obs_mis !== 1 || obs_got_req) begin miscompares++; $display("FAIL rand_mis addr=%h f3=%0d: got pulse=%0d req=%b expected 1/0", addr, f3, obs_mis, obs_got_req); end
        vectors++; if (obs_lat !== 1 || obs_wb_rd_we !== 1'b0) begin miscompares++; $display("FAIL rand_mis_wb: got lat=%0d rd_we=%b expected 1/0", obs_lat, obs_wb_rd_we); end
      end else if (is_st) begin
        ref_store(addr, rs2, size);
        vectors++; if (obs_be !== ref_be(size, off)) begin miscompares++; $display("FAIL rand_st_be addr=%h: got %b expected %b", addr, obs_be, ref_be(size, off)); end
        vectors++; if (obs_wdata !== ref_wdata(rs2, size)) begin miscompares++; $display("FAIL rand_st_wdata: got %h expected %h", obs_wdata, ref_wdata(rs2, size)); end
        vectors++; if (obs_addr !== (addr & 32'hFFFF_FFFC) || obs_we !== 1'b1) begin miscompares++; $display("FAIL rand_st_addr: got %h we=%b expected %h we=1", obs_addr, obs_we, addr & 32'hFFFF_FFFC); end
        vectors++; if (obs_lat !== 2 + rq || obs_stall !== 1 + rq) begin miscompares++; $display("FAIL rand_st_timing rq=%0d: got lat=%0d stall=%0d expected %0d/%0d", rq, obs_lat, obs_stall, 2 + rq, 1 + rq); end
        vectors++; if (obs_wb_rd_we !== 1'b0 || obs_unstable !== 0) begin miscompares++; $display("FAIL rand_st_misc: got rd_we=%b changes=%0d expected 0/0", obs_wb_rd_we, obs_unstable); end
      end else begin
        exp = ref_load(ref_read(addr & 32'hFFFF_FFFC), f3, off);
        vectors++; if (obs_wb_result !== exp) begin miscompares++; $display("FAIL rand_ld_result addr=%h f3=%0d: got %h expected %h", addr, f3, obs_wb_result, exp); end
        vectors++; if (obs_addr !== (addr & 32'hFFFF_FFFC) || obs_we !== 1'b0) begin miscompares++; $display("FAIL rand_ld_addr: got %h we=%b expected %h we=0", obs_addr, obs_we, addr & 32'hFFFF_FFFC); end
        vectors++; if (obs_lat !== 3 + rq + rp || obs_stall !== 2 + rq + rp) begin miscompares++; $display("FAIL rand_ld_timing rq=%0d rp=%0d: got lat=%0d stall=%0d expected %0d/%0d", rq, rp, obs_lat, obs_stall, 3 + rq + rp, 2 + rq + rp); end
        vectors++; if (obs_wb_rd_we !== (rd != 5'd0) || obs_unstable !== 0) begin miscompares++; $display("FAIL rand_ld_misc rd=%0d: got rd_we=%b changes=%0d expected %b/0", rd, obs_wb_rd_we, obs_unstable, rd != 5'd0); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data = $urandom;
    logic [31:0] exp;
    do_op(mk_instr(OP_STORE, 3'b010, 5'd0), 32'h500, data, 0, 0);
    ref_store(32'h500, data, 4);
    vectors++; if (obs_lat !== 2) begin miscompares++; $display("FAIL b2b_sw_latency: got %0d expected 2", obs_lat); end
    do_op(mk_instr(OP_LOAD, 3'b010, 5'd9), 32'h500, 32'h0, 0, 0);
    exp = ref_read(32'h500);
    vectors++; if (obs_req_cycle !== 1) begin miscompares++; $display("FAIL b2b_lw_req_cycle: got %0d expected 1", obs_req_cycle); end
    vectors++; if (obs_lat !== 3) begin miscompares++; $display("FAIL b2b_lw_latency: got %0d expected 3", obs_lat); end
    vectors++; if (obs_wb_result !== exp) begin miscompares++; $display("FAIL b2b_lw_data: got %h expected %h", obs_wb_result, exp); end
  endtask

  task automatic test_reset_mid();
    bus_mem[32'h400] = 32'h1122_3344;
    ref_mem[32'h400] = 32'h1122_3344;
    ex_valid = 1'b1; ex_instruction = mk_instr(OP_LOAD, 3'b010, 5'd3);
    ex_alu_result = 32'h400; ex_rs2_data = 32'h0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (dmem_req_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_req: got %b expected 1", dmem_req_valid); end
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    @(negedge clk);
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL rmid_resp_stall: got %b expected 1", stall); end
    @(posedge clk); #1;
    rst = 1'b1; ex_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_wb_valid: got %b expected 0", wb_valid); end
    vectors++; if (stall !== 1'b0 || dmem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_idle: got stall=%b req=%b expected 0/0", stall, dmem_req_valid); end
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h1122_3344;
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rmid_late_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_late_rsp: got wb_valid=%b expected 0", wb_valid); end
    do_op(mk_instr(7'b0010011, 3'b000, 5'd1), 32'hCAFE_0001, 32'h0, 0, 0);
    vectors++; if (obs_lat !== 1 || obs_wb_result !== 32'hCAFE_0001) begin miscompares++; $display("FAIL rmid_recover: got lat=%0d result=%h expected 1/cafe0001", obs_lat, obs_wb_result); end
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_alu_result = '0; ex_instruction = '0; ex_rs2_data = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_alu();
    test_load();
    test_store_delayed();
    test_misalign();
    test_random_mem();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/kamacore_stage_mem.md
# kamacore_stage_mem

Memory-access stage of the kamacore five-stage RV32I pipeline. It consumes the execute-stage output (ALU result, instruction, store data) and performs LB/LH/LW/LBU/LHU/SB/SH/SW through a valid/ready data-memory port. It stalls upstream while a transaction is outstanding and registers the MEM/WB buffer. Non-memory instructions pass through with one cycle of latency.

## Interface
- No module parameters. `CPU_WIDTH` (32) comes from `kamacore_pkg`.
- `clk` in 1: sole clock; everything updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: EX/MEM entry holds a real instruction.
- `ex_alu_result` in CPU_WIDTH: effective address or ALU result.
- `ex_instruction` in 32: instruction word; opcode/funct3/rd decoded here.
- `ex_rs2_data` in CPU_WIDTH: store data, already forwarded.
- `stall` out 1: upstream must hold the EX/MEM entry while high.
- `dmem_req_valid` out 1: request to data memory.
- `dmem_req_ready` in 1: memory accepts the request this cycle.
- `dmem_addr` out 32: word-aligned address, i.e. `{addr[31:2],2'b00}`.
- `dmem_we` out 1: 1 = store.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-shifted store data.
- `dmem_rsp_valid` in 1: load data valid.
- `dmem_rdata` in 32: full word read.
- `wb_valid` out 1: MEM/WB entry valid.
- `wb_instruction` out 32: instruction carried to WB.
- `wb_result` out CPU_WIDTH: value to write back.
- `wb_rd_we` out 1: register write enable. It is 0 for stores, branches, misaligned accesses and rd==0.
- `misalign_exc` out 1: one-cycle pulse for a misaligned access.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE, with `ex_valid` and a non-memory instruction:
  - Next edge registers `wb_valid=1`, `wb_result=ex_alu_result`, `wb_instruction`, and `wb_rd_we` (rd≠0 and the opcode writes rd).
- IDLE, with `ex_valid` and a memory op:
  - Check alignment: LH/LHU/SH need `addr[0]==0`; LW/SW need `addr[1:0]==0`.
  - Misaligned: no bus request. `misalign_exc`=1 this cycle. Next edge registers `wb_valid=1`, `wb_rd_we=0`. Stay in IDLE, `stall`=0.
  - Aligned: latch address, funct3, rd, store data and instruction. Go to REQ. `stall`=1.
- REQ: `dmem_req_valid`=1, outputs driven from latched values.
  - Not ready: remain in REQ.
  - Ready, store: go to IDLE. Next edge registers `wb_valid=1`, `wb_rd_we=0`.
  - Ready, load: go to RESP.
- RESP: wait for `dmem_rsp_valid`.
  - On response, extract the lane at byte offset `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
  - Register into MEM/WB and go to IDLE.
- Store lanes:
  - SB: `be = 4'b0001<<addr[1:0]`, `wdata = {4{rs2[7:0]}}`.
  - SH: `be = 4'b0011<<addr[1:0]`, `wdata = {2{rs2[15:0]}}`.
  - SW: `be = 4'b1111`.
- `wb_valid`=0 (bubble) on every edge where no instruction completes.
- `dmem_rsp_valid` arriving in IDLE or REQ is ignored.
- Memory must not respond before accepting the request.

## Timing
- Reset values: state IDLE; `wb_valid`, `wb_instruction`, `wb_result`, `wb_rd_we` = 0; `dmem_req_valid`=0; `stall`=0; `misalign_exc`=0.
- `stall` is combinational and high when any of the following holds:
  - state IDLE & `ex_valid` & aligned memory op;
  - state REQ & !(store & `dmem_req_ready`);
  - state RESP & !`dmem_rsp_valid`.
- Latencies, each measured from the EX entry presented in cycle 0:
  - Non-memory op: visible on WB outputs in cycle 1.
  - Store, zero-wait memory: request in cycle 1, WB in cycle 2.
  - Load, zero-wait memory: request in cycle 1, response in cycle 2, WB in cycle 3.
- Each wait cycle of ready or response adds exactly one cycle.
- `dmem_*` outputs stay stable while `dmem_req_valid` is held without ready.
- Reset mid-transaction (REQ or RESP): return to IDLE next edge, drop the transaction, and produce no WB entry.

## Structure
- `kamacore_pkg` holds:
  - `CPU_WIDTH`;
  - opcode constants `OPCODE_LOAD` (7'b0000011) and `OPCODE_STORE` (7'b0100011);
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - enum `mem_state_e` {IDLE, REQ, RESP}.
- Sub-module `kamacore_lsu_align` is purely combinational. It produces `be`, `wdata`, the misalign flag and load extraction/extension from funct3, `addr[1:0]`, rs2 and rdata.
- FSM, latches and MEM/WB register live in `kamacore_stage_mem`.

## Test plan
- ADD result 0x0000_1234, rd=5 → cycle 1: `wb_valid=1`, `wb_result=0x1234`, `wb_rd_we=1`, `stall` never high.
- LB at 0x103 with rdata 0x80FF_0000, zero-wait → `dmem_addr=0x100`, WB `wb_result=0xFFFF_FF80` in cycle 3; the same access as LBU → `0x0000_0080`.
- SH rs2=0xDEAD_BEEF at 0x202, ready delayed 2 cycles → `be=4'b1100`, `wdata=0xBEEF_BEEF`, `stall` high 3 cycles, `wb_rd_we=0`.
- LW at 0x301 → `misalign_exc` 1 cycle, no `dmem_req_valid`, `wb_valid=1`, `wb_rd_we=0`.
- LW at 0x400, response delayed 3 cycles, `rst` asserted in RESP → next edge state IDLE, `wb_valid=0`, late `rsp_valid` ignored.
- Back-to-back SW then LW to 0x500 → second op starts REQ the cycle after the store completes, and the load returns the stored word.
